mem_arbiter: RTL

Two-port memory arbiter between the instruction cache, the data cache and the single main-memory port. It forwards each cache's command and write-data channels to memory with round-robin arbitration. It records the requester of every outstanding read in an in-order ID FIFO and steers each memory response beat back to the cache that issued the read. All request and response paths are combinational pass-throughs, so the block adds zero cycles of latency. State consists of the grant pointer, the write-lock FSM and the ID FIFO.

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between icache and dcache.
// Read responses are steered back through an in-order requester-ID FIFO.
module mem_arbiter #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned ID_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int unsigned PtrBits = $clog2(ID_DEPTH);
    localparam int unsigned CntBits = PtrBits + 1;
    localparam logic [CntBits-1:0] DepthCnt = CntBits'(ID_DEPTH);

    typedef enum logic {StIdle, StWlock} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;  // 0 = icache, 1 = dcache
    logic   lock_id_q, lock_id_d;

    logic               id_mem_q [ID_DEPTH];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q;

    logic fifo_full, fifo_empty, push, push_id, pop, head_id;
    logic ic_elig, dc_elig, grant_any, grant_dc;
    logic data_fwd, data_dc, data_fire;

    assign fifo_full  = (count_q == DepthCnt);
    assign fifo_empty = (count_q == '0);
    assign ic_elig    = ic_req_valid & (ic_req_rw | ~fifo_full);
    assign dc_elig    = dc_req_valid & (dc_req_rw | ~fifo_full);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_id_d    = lock_id_q;
        push         = 1'b0;
        push_id      = 1'b0;
        grant_any    = 1'b0;
        grant_dc     = 1'b0;
        data_fwd     = 1'b0;
        data_dc      = 1'b0;
        data_fire    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = ic_req_addr;
        mem_req_rw    = ic_req_rw;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_any = ic_elig | dc_elig;
                grant_dc  = dc_elig & (~ic_elig | ~last_grant_q);
                if (grant_any) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = grant_dc ? dc_req_addr : ic_req_addr;
                    mem_req_rw    = grant_dc ? dc_req_rw : ic_req_rw;
                    ic_req_ready  = ~grant_dc & mem_req_ready;
                    dc_req_ready  = grant_dc & mem_req_ready;
                    if (mem_req_rw) begin
                        data_fwd  = 1'b1;
                        data_dc   = grant_dc;
                        data_fire = (grant_dc ? dc_req_data_valid : ic_req_data_valid)
                                    & mem_req_data_ready;
                    end
                    if (mem_req_ready) begin
                        last_grant_d = grant_dc;
                        if (mem_req_rw) begin
                            if (!data_fire) begin
                                state_d   = StWlock;
                                lock_id_d = grant_dc;
                            end
                        end else begin
                            push    = 1'b1;
                            push_id = grant_dc;
                        end
                    end
                end
            end
            StWlock: begin
                data_fwd  = 1'b1;
                data_dc   = lock_id_q;
                data_fire = (lock_id_q ? dc_req_data_valid : ic_req_data_valid)
                            & mem_req_data_ready;
                if (data_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Handshake outputs read as idle while reset is held, whatever the inputs.
        if (!reset) begin
            mem_req_valid = 1'b0;
            ic_req_ready  = 1'b0;
            dc_req_ready  = 1'b0;
            data_fwd      = 1'b0;
        end
    end

    always_comb begin
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = ic_req_data_bits;
        mem_req_data_mask  = ic_req_data_mask;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        if (data_fwd) begin
            if (data_dc) begin
                mem_req_data_valid = dc_req_data_valid;
                mem_req_data_bits  = dc_req_data_bits;
                mem_req_data_mask  = dc_req_data_mask;
                dc_req_data_ready  = mem_req_data_ready;
            end else begin
                mem_req_data_valid = ic_req_data_valid;
                ic_req_data_ready  = mem_req_data_ready;
            end
        end
    end

    // Responses with nothing outstanding are silently dropped.
    assign head_id       = id_mem_q[rd_ptr_q];
    assign pop           = reset & mem_resp_valid & ~fifo_empty;
    assign ic_resp_valid = pop & ~head_id;
    assign dc_resp_valid = pop & head_id;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            lock_id_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_id_q    <= lock_id_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrBits'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrBits'(1);
            if (push && !pop)      count_q <= count_q + CntBits'(1);
            else if (pop && !push) count_q <= count_q - CntBits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_mem_q[wr_ptr_q] <= push_id;
    end

endmodule
